// File: rtl/rom_arbiter_if.sv
// Bundle of the two read ports and the ROM side of rom_arbiter.
// master: requester/ROM environment side, slave: the arbiter.
interface rom_arbiter_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        load_req;
  logic [15:0] load_addr;
  logic        load_gnt;
  logic        load_valid;
  logic [15:0] load_data;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, rom_data,
    output fetch_gnt, fetch_valid, fetch_data,
    output load_gnt, load_valid, load_data, rom_addr
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, rom_data,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  load_gnt, load_valid, load_data, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port (fetch / load) arbiter in front of a single combinational ROM.
// One ROM access per cycle, grants are combinational, read data is
// registered per port with a one-cycle valid pulse.
// Build option: define ROM_ARB_RR_EN for round-robin arbitration;
// otherwise load has fixed priority over fetch.
module rom_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  rom_arbiter_if.slave  bus
);
  logic        fetch_gnt_d, load_gnt_d;
  logic [15:0] rom_addr_d, rom_addr_q;
  logic        fetch_valid_q, load_valid_q;
  logic [15:0] fetch_data_q, load_data_q;

`ifdef ROM_ARB_RR_EN
  // Pointer: 1 = load was granted most recently, 0 = fetch (reset value).
  logic last_load_q;

  // Round-robin grant; a lone requester always wins, contest goes to the
  // port that was not granted last. No grants while reset is held.
  always_comb begin
    fetch_gnt_d = 1'b0;
    load_gnt_d  = 1'b0;
    if (rst_n) begin
      if (bus.fetch_req && bus.load_req) begin
        fetch_gnt_d = last_load_q;
        load_gnt_d  = ~last_load_q;
      end else begin
        fetch_gnt_d = bus.fetch_req;
        load_gnt_d  = bus.load_req;
      end
    end
  end

  // Pointer only moves on granted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_load_q <= 1'b0;
    else if (load_gnt_d) last_load_q <= 1'b1;
    else if (fetch_gnt_d) last_load_q <= 1'b0;
  end
`else
  // Fixed priority grant: load beats fetch. No grants while reset is held.
  always_comb begin
    load_gnt_d  = rst_n & bus.load_req;
    fetch_gnt_d = rst_n & bus.fetch_req & ~bus.load_req;
  end
`endif

  // ROM address follows the granted port, otherwise holds the last one.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (load_gnt_d)       rom_addr_d = bus.load_addr;
    else if (fetch_gnt_d) rom_addr_d = bus.fetch_addr;
  end

  // Capture ROM word into the granted port; valid pulses for one cycle.
  // Async reset clears valids, so a grant in flight at reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q    <= 16'h0000;
      fetch_valid_q <= 1'b0;
      load_valid_q  <= 1'b0;
      fetch_data_q  <= 16'h0000;
      load_data_q   <= 16'h0000;
    end else begin
      rom_addr_q    <= rom_addr_d;
      fetch_valid_q <= fetch_gnt_d;
      load_valid_q  <= load_gnt_d;
      if (fetch_gnt_d) fetch_data_q <= bus.rom_data;
      if (load_gnt_d)  load_data_q  <= bus.rom_data;
    end
  end

  assign bus.fetch_gnt   = fetch_gnt_d;
  assign bus.load_gnt    = load_gnt_d;
  assign bus.rom_addr    = rom_addr_d;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.load_valid  = load_valid_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.load_data   = load_data_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Table-driven bench for rom_arbiter with a per-port scoreboard of
// expected read words, plus hand-written reset corner cases.
module tb_rom_arbiter;
  logic clk;
  logic rst_n;

  rom_arbiter_if bus();

  rom_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ROM: 16 words, zero beyond the last word.
  function automatic logic [15:0] rom_model(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h700F;
      16'd1:   return 16'h8002;
      16'd2:   return 16'h8001;
      16'd3:   return 16'h6BE8;
      16'd4:   return 16'hED15;
      16'd5:   return 16'h1234;
      16'd6:   return 16'h8880;
      16'd7:   return 16'h5803;
      16'd8:   return 16'h6805;
      16'd9:   return 16'hA5A5;
      16'd15:  return 16'hFFFF;
      default: return (a < 16'd16) ? 16'h0F0F : 16'h0000;
    endcase
  endfunction

  assign bus.rom_data = rom_model(bus.rom_addr);

  typedef struct {
    logic        freq;
    logic [15:0] faddr;
    logic        lreq;
    logic [15:0] laddr;
    logic        egf;
    logic        egl;
    logic [15:0] eword;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] fq[$];
  logic [15:0] lq[$];
  logic [15:0] last_f, last_l, exp_ra;
  int          passed = 0;
  int          total  = 0;

  function automatic vec_t mk(input logic fr, input logic [15:0] fa,
                              input logic lr, input logic [15:0] la,
                              input logic ef, input logic el,
                              input logic [15:0] w);
    vec_t v;
    v.freq = fr; v.faddr = fa; v.lreq = lr; v.laddr = la;
    v.egf = ef; v.egl = el; v.eword = w;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of requests, check grants/rom_addr mid-cycle, push the
  // expected word, then check valid/data after the edge from the scoreboard.
  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.fetch_req  = v.freq;
    bus.fetch_addr = v.faddr;
    bus.load_req   = v.lreq;
    bus.load_addr  = v.laddr;
    #1;
    chk1("fetch_gnt", bus.fetch_gnt, v.egf);
    chk1("load_gnt", bus.load_gnt, v.egl);
    if (v.egf) begin fq.push_back(v.eword); exp_ra = v.faddr; end
    if (v.egl) begin lq.push_back(v.eword); exp_ra = v.laddr; end
    chk16("rom_addr", bus.rom_addr, exp_ra);
    @(posedge clk);
    #1;
    chk1("fetch_valid", bus.fetch_valid, v.egf);
    if ((bus.fetch_valid || v.egf) && fq.size() > 0) last_f = fq.pop_front();
    chk16("fetch_data", bus.fetch_data, last_f);
    chk1("load_valid", bus.load_valid, v.egl);
    if ((bus.load_valid || v.egl) && lq.size() > 0) last_l = lq.pop_front();
    chk16("load_data", bus.load_data, last_l);
  endtask

  task automatic clear_model();
    fq.delete();
    lq.delete();
    last_f = 16'h0000;
    last_l = 16'h0000;
    exp_ra = 16'h0000;
  endtask

  // Hold reset with both requests asserted; nothing may be granted.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0003;
    bus.load_req   = 1'b1;
    bus.load_addr  = 16'h0004;
    clear_model();
    #1;
    chk1("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
    chk1("rst_load_gnt", bus.load_gnt, 1'b0);
    chk16("rst_rom_addr", bus.rom_addr, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_fetch_valid", bus.fetch_valid, 1'b0);
    chk1("rst_load_valid", bus.load_valid, 1'b0);
    chk16("rst_fetch_data", bus.fetch_data, 16'h0000);
    chk16("rst_load_data", bus.load_data, 16'h0000);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.load_req  = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 16'h0000;
    bus.load_req   = 1'b0;
    bus.load_addr  = 16'h0000;
    clear_model();

    tbl.push_back(mk(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h700F));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h8001));
    tbl.push_back(mk(1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8002));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h0006, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h8880));
    tbl.push_back(mk(1'b1, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h5803));
    tbl.push_back(mk(1'b1, 16'h0008, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h6805));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));
`ifdef ROM_ARB_RR_EN
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h6BE8));
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h6BE8));
`else
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
    tbl.push_back(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
`endif
    tbl.push_back(mk(1'b1, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h6BE8));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 1'b1, 16'hA5A5));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b1, 16'hFFFF));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0000));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Fetch granted, then reset lands before the capturing edge.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0005;
    #1;
    chk1("midrst_fetch_gnt", bus.fetch_gnt, 1'b1);
    #1;
    rst_n = 1'b0;
    bus.fetch_req = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    chk1("midrst_valid_in_rst", bus.fetch_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("midrst_fetch_valid", bus.fetch_valid, 1'b0);
    chk16("midrst_fetch_data", bus.fetch_data, 16'h0000);
    chk16("midrst_rom_addr", bus.rom_addr, 16'h0000);

    // First contested grant after reset goes to load in either policy.
    apply(mk(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hED15));
    apply(mk(1'b1, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h6BE8));
    apply(mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));

    chk16("fetch_sb_empty", 16'(fq.size()), 16'h0000);
    chk16("load_sb_empty", 16'(lq.size()), 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
